cbus_arbiter: RTL

- Sits directly downstream of DCache (and ICache) and upstream of the memory/AXI bridge.
- Multiplexes N cache-side cbus masters onto the single shared cbus.
- Once a master is granted, it holds the bus for its whole burst, until the final beat is acknowledged.
- Arbitration is either round-robin or fixed priority, selected by parameter.

---
 rtl/cbus_pkg.sv | 22 ++
 rtl/cbus_arbiter.sv | 109 ++++++++++
 2 files changed

// File: rtl/cbus_pkg.sv
// Request/response structures shared by the cache-side cbus masters,
// the arbiter and the memory/AXI bridge.
package cbus_pkg;

    typedef struct packed {
        logic        valid;
        logic        is_write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [3:0]  strobe;
        logic [31:0] data;
        logic [7:0]  len;
        logic [1:0]  burst;
    } cbus_req_t;

    typedef struct packed {
        logic        ready;
        logic        last;
        logic [31:0] data;
    } cbus_resp_t;

endpackage

// File: rtl/cbus_arbiter.sv
// Burst-locked arbiter that muxes N cache-side cbus masters onto one shared cbus,
// using either round-robin or fixed (highest index wins) priority.
module cbus_arbiter
    import cbus_pkg::*;
#(
    parameter int N_MASTERS  = 2,
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       reset_,
    input  cbus_req_t  ireqs  [N_MASTERS],
    output cbus_resp_t iresps [N_MASTERS],
    output cbus_req_t  oreq,
    input  cbus_resp_t oresp
);

    localparam int IDX_W = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   owner;
    logic [IDX_W-1:0]   owner_next;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_next;
    logic [IDX_W-1:0]   winner;
    logic               any_valid;
    logic               burst_done;

    assign burst_done = oresp.ready && oresp.last;

    // Scan order starts at rr_ptr; iterating downwards lets the closest valid index win.
    always_comb begin
        winner    = '0;
        any_valid = 1'b0;
        if (FIXED_PRIO != 0) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (ireqs[i].valid) begin
                    winner    = IDX_W'(i);
                    any_valid = 1'b1;
                end
            end
        end else begin
            for (int k = N_MASTERS - 1; k >= 0; k--) begin
                int cand;
                cand = int'(rr_ptr) + k;
                if (cand >= N_MASTERS) begin
                    cand = cand - N_MASTERS;
                end
                if (ireqs[cand].valid) begin
                    winner    = IDX_W'(cand);
                    any_valid = 1'b1;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments and a synchronous reset;
    // every always_comb below assigns each output a default first so no latch is inferred.
    always_ff @(posedge clk) begin
        if (!reset_) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
        end else begin
            state  <= state_next;
            owner  <= owner_next;
            rr_ptr <= rr_next;
        end
    end

    always_comb begin
        state_next = state;
        owner_next = owner;
        rr_next    = rr_ptr;
        case (state)
            IDLE: begin
                if (any_valid) begin
                    state_next = BUSY;
                    owner_next = winner;
                end
            end
            BUSY: begin
                if (burst_done) begin
                    state_next = IDLE;
                    rr_next    = (owner == IDX_W'(N_MASTERS - 1)) ? '0 : owner + IDX_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Outputs depend only on registered state plus the pass-through data paths.
    always_comb begin
        oreq = '0;
        for (int j = 0; j < N_MASTERS; j++) begin
            iresps[j] = '0;
        end
        if (state == BUSY) begin
            oreq          = ireqs[owner];
            iresps[owner] = oresp;
        end
    end

endmodule
